elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
Call scheduler and door sequencer for the 4-floor elevator car datapath. It latches floor call requests into a pending set and drives the datapath's one-hot requested-floor input. It reads back the one-hot current floor, serves calls in SCAN order (keep direction while calls remain ahead) and times the door-open dwell at each served floor.

Parameters:
DOOR_CYCLES, 8, clk cycles door_open stays high per stop (>=2)
TMR_W, 4, door timer width; must hold DOOR_CYCLES-1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
call_req  input  4  per-floor call, bit0 = ground; level, sampled every cycle
cur_floor  input  4  one-hot current floor from car datapath
tgt_floor  output  4  one-hot floor request to car datapath
door_open  output  1  door open command
dir_up  output  1  car commanded upward (MOVE_UP)
dir_dn  output  1  car commanded downward (MOVE_DN)
pending  output  4  latched unserved calls
fault  output  1  cur_floor not one-hot this cycle (combinational)

Behaviour:
- Reset (async, any state, incl. mid-dwell): state=IDLE, pending=0, tgt_floor=4'b0001, door_open=0, dir_up=dir_dn=0, last_dir=UP, timer=0.
- Definitions: here = pending & cur_floor; above = pending bits strictly higher than the set cur_floor bit; below = pending bits strictly lower.
- Pending update each cycle: pending <= (pending | call_req) & ~clr. clr = cur_floor on the cycle the FSM enters or stays in DOOR_OPEN, else 0. A call at the current floor during DOOR_OPEN is not latched and reloads the timer.
- Latency: call_req to pending is 1 cycle. Pending to state change is 1 cycle, so an idle car reacts 2 cycles after a call.
- IDLE: door_open=0, dir_up=dir_dn=0, tgt_floor=cur_floor.
  - here!=0 -> DOOR_OPEN.
  - else above/below nonzero -> MOVE in last_dir if calls lie that way, otherwise the opposite direction.
  - else stay.
- MOVE_UP: dir_up=1, last_dir=UP, tgt_floor = lowest set bit of above.
  - When here!=0 -> DOOR_OPEN.
  - A new call between car and target retargets next cycle (nearest first).
- MOVE_DN: mirror of MOVE_UP. dir_dn=1, last_dir=DN, tgt_floor = highest set bit of below.
- DOOR_OPEN: door_open=1, tgt_floor=cur_floor, dir_up=dir_dn=0.
  - Timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - Exit when timer==0: to MOVE in last_dir if calls lie that way, else the opposite direction, else IDLE.
  - door_open is high for exactly DOOR_CYCLES cycles per stop, absent reloads.
- Simultaneous calls above and below while IDLE: last_dir wins; after reset that is UP.
- Top floor (bit3) and ground (bit0): no above/below exists beyond them. The car never requests out of range.
- fault=1: FSM, pending, timer and outputs hold their values, no clears. Normal operation resumes on the first cycle cur_floor is one-hot again.
- Outputs tgt_floor, door_open, dir_up, dir_dn and pending are registered.

Test Plan:
- Reset with cur_floor=0001, no calls -> tgt_floor=0001, door_open=0, pending=0, state IDLE indefinitely.
- cur_floor=0001, 1-cycle call_req=0001 -> door_open high cycles 3..10 (DOOR_CYCLES=8), pending stays 0000.
- cur_floor=0001, call_req=1000 then 0100 while moving -> tgt_floor 1000, then 0100.
  - Car stops at floor 2 (door 8 cycles), then tgt_floor=1000 with dir_up=1.
- Car at 0010 going UP, pending={0001,1000} -> serves 1000 first, then reverses: dir_dn=1, tgt_floor=0001.
- cur_floor=0110 for 5 cycles mid-MOVE -> fault=1 and all outputs frozen. Resumes when cur_floor becomes 0100.
- Assert rst during DOOR_OPEN with pending=1000 -> door_open=0 and pending=0 immediately (async), no motion after release.

Source files
------------

// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the call scheduler and the 4-floor car datapath.
// The scheduler takes the master side; the car/call-panel side uses slave.
interface elevator_call_scheduler_if;
  logic [3:0] call_req;
  logic [3:0] cur_floor;
  logic [3:0] tgt_floor;
  logic       door_open;
  logic       dir_up;
  logic       dir_dn;
  logic [3:0] pending;
  logic       fault;

  modport master (
    input  call_req,
    input  cur_floor,
    output tgt_floor,
    output door_open,
    output dir_up,
    output dir_dn,
    output pending,
    output fault
  );

  modport slave (
    output call_req,
    output cur_floor,
    input  tgt_floor,
    input  door_open,
    input  dir_up,
    input  dir_dn,
    input  pending,
    input  fault
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN-order call scheduler and door dwell sequencer for a 4-floor car.
// Latches calls, requests the next floor one-hot and times the door at each stop.
module elevator_call_scheduler #(
  parameter int DOOR_CYCLES = 8,
  parameter int TMR_W       = 4
) (
  input logic                       clk,
  input logic                       rst,
  elevator_call_scheduler_if.master bus
);

  localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DN   = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t           state_reg;
  logic [3:0]       pending_reg;
  logic [3:0]       tgt_floor_reg;
  logic             door_open_reg;
  logic             dir_up_reg;
  logic             dir_dn_reg;
  logic             last_up_reg;
  logic [TMR_W-1:0] timer_reg;

  logic [3:0] above_mask;
  logic [3:0] below_mask;
  logic [3:0] here;
  logic [3:0] above;
  logic [3:0] below;
  logic [3:0] merged;
  logic [3:0] up_tgt;
  logic [3:0] dn_tgt;
  logic       fault_w;
  logic       reload;
  logic       keep_dwell;
  logic       go_up;
  logic       go_dn;

  function automatic logic [3:0] highest_bit(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 4'(1 << i);
    end
    return r;
  endfunction

  // Floor gi is above the car when the car's bit sits strictly below gi, and vice versa.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_floor_mask
      localparam logic [3:0] BIT_GI = 4'(1 << gi);
      localparam logic [3:0] LOWER  = BIT_GI - 4'd1;
      localparam logic [3:0] UPPER  = ~(LOWER | BIT_GI);
      assign above_mask[gi] = |(bus.cur_floor & LOWER);
      assign below_mask[gi] = |(bus.cur_floor & UPPER);
    end
  endgenerate

  assign fault_w = (bus.cur_floor == 4'd0) ||
                   ((bus.cur_floor & (bus.cur_floor - 4'd1)) != 4'd0);

  assign here   = pending_reg & bus.cur_floor;
  assign above  = pending_reg & above_mask;
  assign below  = pending_reg & below_mask;
  assign merged = pending_reg | bus.call_req;
  assign up_tgt = above & (~above + 4'd1);
  assign dn_tgt = highest_bit(below);

  // Keep the last travel direction while calls remain that way, else reverse.
  assign go_up = last_up_reg ? (above != 4'd0) : ((above != 4'd0) && (below == 4'd0));
  assign go_dn = last_up_reg ? ((above == 4'd0) && (below != 4'd0)) : (below != 4'd0);

  assign reload     = |(bus.call_req & bus.cur_floor);
  assign keep_dwell = (state_reg == DOOR_OPEN) && (reload || (timer_reg != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pending_reg   <= 4'b0000;
      tgt_floor_reg <= 4'b0001;
      door_open_reg <= 1'b0;
      dir_up_reg    <= 1'b0;
      dir_dn_reg    <= 1'b0;
      last_up_reg   <= 1'b1;
      timer_reg     <= '0;
    end else if (!fault_w) begin
      pending_reg <= merged;
      if (keep_dwell) begin
        pending_reg <= merged & ~bus.cur_floor;
        timer_reg   <= reload ? DWELL_LOAD : timer_reg - TMR_W'(1);
      end else if (here != 4'd0) begin
        state_reg     <= DOOR_OPEN;
        pending_reg   <= merged & ~bus.cur_floor;
        timer_reg     <= DWELL_LOAD;
        tgt_floor_reg <= bus.cur_floor;
        door_open_reg <= 1'b1;
        dir_up_reg    <= 1'b0;
        dir_dn_reg    <= 1'b0;
      end else if (go_up) begin
        state_reg     <= MOVE_UP;
        last_up_reg   <= 1'b1;
        tgt_floor_reg <= up_tgt;
        door_open_reg <= 1'b0;
        dir_up_reg    <= 1'b1;
        dir_dn_reg    <= 1'b0;
      end else if (go_dn) begin
        state_reg     <= MOVE_DN;
        last_up_reg   <= 1'b0;
        tgt_floor_reg <= dn_tgt;
        door_open_reg <= 1'b0;
        dir_up_reg    <= 1'b0;
        dir_dn_reg    <= 1'b1;
      end else begin
        state_reg     <= IDLE;
        tgt_floor_reg <= bus.cur_floor;
        door_open_reg <= 1'b0;
        dir_up_reg    <= 1'b0;
        dir_dn_reg    <= 1'b0;
      end
    end
  end

  assign bus.tgt_floor = tgt_floor_reg;
  assign bus.door_open = door_open_reg;
  assign bus.dir_up    = dir_up_reg;
  assign bus.dir_dn    = dir_dn_reg;
  assign bus.pending   = pending_reg;
  assign bus.fault     = fault_w;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: expectations are queued with the
// stimulus and checked against the outputs just after the following clock edge.
module tb_elevator_call_scheduler;

  typedef struct {
    string      tag;
    logic [11:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  elevator_call_scheduler_if bus ();

  elevator_call_scheduler #(
    .DOOR_CYCLES(8),
    .TMR_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [3:0] tgt, input logic door,
                            input logic up, input logic dn, input logic [3:0] pend,
                            input logic flt);
    exp_t e;
    e.tag = tag;
    e.val = {tgt, door, up, dn, pend, flt};
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [11:0] obs;
    obs = {bus.tgt_floor, bus.door_open, bus.dir_up, bus.dir_dn, bus.pending, bus.fault};
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed={tgt,door,up,dn,pend,fault}=%03h expected=%03h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Door held open at floor tgt with the given pending set for n further cycles.
  task automatic door_hold(input string tag, input logic [3:0] tgt, input logic [3:0] pend,
                           input int n);
    for (int i = 0; i < n; i++) begin
      expect_out($sformatf("%s_door%0d", tag, i), tgt, 1'b1, 1'b0, 1'b0, pend, 1'b0);
      tick();
    end
  endtask

  initial begin
    bus.call_req  = 4'b0000;
    bus.cur_floor = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("reset", 4'b0001, 0, 0, 0, 4'b0000, 0);
    check_now();

    // Idle with no calls
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("idle%0d", i), 4'b0001, 0, 0, 0, 4'b0000, 0);
      tick();
    end

    // One-cycle call at the current floor
    bus.call_req = 4'b0001;
    expect_out("here_latch", 4'b0001, 0, 0, 0, 4'b0001, 0);
    tick();
    bus.call_req = 4'b0000;
    door_hold("here", 4'b0001, 4'b0000, 8);
    expect_out("here_close", 4'b0001, 0, 0, 0, 4'b0000, 0);
    tick();

    // Call to the top, then a nearer call while moving up
    bus.call_req = 4'b1000;
    expect_out("top_latch", 4'b0001, 0, 0, 0, 4'b1000, 0);
    tick();
    bus.call_req = 4'b0000;
    expect_out("top_move", 4'b1000, 0, 1, 0, 4'b1000, 0);
    tick();
    bus.call_req = 4'b0100;
    expect_out("mid_latch", 4'b1000, 0, 1, 0, 4'b1100, 0);
    tick();
    bus.call_req = 4'b0000;
    expect_out("retarget", 4'b0100, 0, 1, 0, 4'b1100, 0);
    tick();
    bus.cur_floor = 4'b0010;
    expect_out("pass_f1", 4'b0100, 0, 1, 0, 4'b1100, 0);
    tick();
    bus.cur_floor = 4'b0100;
    door_hold("stop_f2", 4'b0100, 4'b1000, 8);
    expect_out("resume_up", 4'b1000, 0, 1, 0, 4'b1000, 0);
    tick();

    // Ground call while heading up: finish the top first, then reverse
    bus.call_req = 4'b0001;
    expect_out("gnd_latch", 4'b1000, 0, 1, 0, 4'b1001, 0);
    tick();
    bus.call_req  = 4'b0000;
    bus.cur_floor = 4'b1000;
    door_hold("stop_top", 4'b1000, 4'b0001, 8);
    expect_out("reverse_dn", 4'b0001, 0, 0, 1, 4'b0001, 0);
    tick();

    // cur_floor not one-hot: everything frozen, calls ignored
    bus.cur_floor = 4'b0110;
    bus.call_req  = 4'b0010;
    #1;
    expect_out("fault_comb", 4'b0001, 0, 0, 1, 4'b0001, 1);
    check_now();
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("fault_hold%0d", i), 4'b0001, 0, 0, 1, 4'b0001, 1);
      tick();
    end
    bus.cur_floor = 4'b0100;
    bus.call_req  = 4'b0000;
    #1;
    expect_out("fault_clear", 4'b0001, 0, 0, 1, 4'b0001, 0);
    check_now();
    expect_out("resume_f2", 4'b0001, 0, 0, 1, 4'b0001, 0);
    tick();
    bus.cur_floor = 4'b0010;
    expect_out("pass_f1_dn", 4'b0001, 0, 0, 1, 4'b0001, 0);
    tick();
    bus.cur_floor = 4'b0001;
    door_hold("stop_gnd", 4'b0001, 4'b0000, 8);
    expect_out("idle_gnd", 4'b0001, 0, 0, 0, 4'b0000, 0);
    tick();

    // Calls above and below while idle: last direction (down) wins
    bus.cur_floor = 4'b0010;
    bus.call_req  = 4'b0101;
    expect_out("split_latch", 4'b0010, 0, 0, 0, 4'b0101, 0);
    tick();
    bus.call_req = 4'b0000;
    expect_out("split_dn", 4'b0001, 0, 0, 1, 4'b0101, 0);
    tick();
    bus.cur_floor = 4'b0001;
    door_hold("split_gnd", 4'b0001, 4'b0100, 8);
    expect_out("split_up", 4'b0100, 0, 1, 0, 4'b0100, 0);
    tick();
    bus.cur_floor = 4'b0010;
    expect_out("split_pass", 4'b0100, 0, 1, 0, 4'b0100, 0);
    tick();
    bus.cur_floor = 4'b0100;
    door_hold("split_f2", 4'b0100, 4'b0000, 1);
    bus.call_req = 4'b1000;
    door_hold("f2_call", 4'b0100, 4'b1000, 1);
    bus.call_req = 4'b0000;
    door_hold("f2_wait", 4'b0100, 4'b1000, 1);

    // Asynchronous reset in the middle of a dwell
    rst = 1'b1;
    bus.cur_floor = 4'b0001;
    #1;
    expect_out("async_rst", 4'b0001, 0, 0, 0, 4'b0000, 0);
    check_now();
    expect_out("rst_hold", 4'b0001, 0, 0, 0, 4'b0000, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("post_rst%0d", i), 4'b0001, 0, 0, 0, 4'b0000, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
